// File: rtl/xform_buf.sv
// -----------------------------------------------------------------------------
// xform_buf
// Small FIFO that applies a character-case transform to each entry as it is
// written. The transform acts on the low byte only; upper bits pass through.
//
// Parameters
//    N  data bus width in bits (N >= 8)
//    K  log2 of buffer depth, DEPTH = 2**K (K >= 1)
//
// Ports
//    i_clk   system clock, all state changes on its rising edge
//    i_rst   synchronous active-high reset
//    i_mode  transform select, sampled with each accepted write
//            0 pass, 1 swap case, 2 to upper, 3 to lower
//    i_wr    write request
//    i_data  write data
//    o_bsy   buffer full (registered)
//    i_rd    read request
//    o_data  head entry (registered)
//    o_rdy   buffer non-empty (registered)
//    o_cnt   current occupancy, 0..DEPTH
//    o_ovf   sticky flag, set by a write attempt while full
// -----------------------------------------------------------------------------
module xform_buf #(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [1:0]   i_mode,
   input  logic         i_wr,
   input  logic [N-1:0] i_data,
   output logic         o_bsy,
   input  logic         i_rd,
   output logic [N-1:0] o_data,
   output logic         o_rdy,
   output logic [K:0]   o_cnt,
   output logic         o_ovf
);

   localparam int DEPTH = 2**K;

   logic [N-1:0] mem [DEPTH];
   logic [K-1:0] wr_ptr;
   logic [K-1:0] rd_ptr;
   logic [K-1:0] rd_ptr_inc;
   logic         wr_en;
   logic         rd_en;
   logic [N-1:0] wr_val;
   logic [K:0]   cnt_next;

   // Case transform on a single byte. Letters outside the range that the
   // selected mode touches come through untouched.
   function automatic logic [7:0] xform(input logic [1:0] mode, input logic [7:0] c);
      logic is_upper;
      logic is_lower;
      logic [7:0] r;
      is_upper = (c >= 8'h41) && (c <= 8'h5A);
      is_lower = (c >= 8'h61) && (c <= 8'h7A);
      r = c;
      case (mode)
         2'd1:    if (is_upper || is_lower) r = c ^ 8'h20;
         2'd2:    if (is_lower) r = c ^ 8'h20;
         2'd3:    if (is_upper) r = c ^ 8'h20;
         default: r = c;
      endcase
      return r;
   endfunction

   // Qualified requests and the next occupancy. A write is blocked while full
   // and a read is ignored while empty, so the count never leaves 0..DEPTH.
   always_comb begin
      wr_en      = i_wr && !o_bsy;
      rd_en      = i_rd && o_rdy;
      wr_val     = {i_data[N-1:8], xform(i_mode, i_data[7:0])};
      rd_ptr_inc = rd_ptr + K'(1);
      cnt_next   = o_cnt;
      case ({wr_en, rd_en})
         2'b10:   cnt_next = o_cnt + (K+1)'(1);
         2'b01:   cnt_next = o_cnt - (K+1)'(1);
         default: cnt_next = o_cnt;
      endcase
   end

   // Storage array holds transformed values; it carries no reset since the
   // occupancy count alone decides which entries are meaningful.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_val;
      end
   end

   // Control state and the registered head output. o_data must show the new
   // head at the same edge that changes it, so on a read it loads the entry
   // behind the current head, or the value being written if that entry is
   // only now arriving. A write into an empty buffer loads o_data directly.
   // When the last entry is read with nothing arriving, o_data holds.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         o_cnt  <= '0;
         o_rdy  <= 1'b0;
         o_bsy  <= 1'b0;
         o_ovf  <= 1'b0;
         o_data <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + K'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr_inc;
            if (o_cnt > (K+1)'(1)) begin
               o_data <= mem[rd_ptr_inc];
            end else if (wr_en) begin
               o_data <= wr_val;
            end
         end else if (wr_en && !o_rdy) begin
            o_data <= wr_val;
         end
         o_cnt <= cnt_next;
         o_rdy <= (cnt_next != '0);
         o_bsy <= (cnt_next == (K+1)'(DEPTH));
         if (i_wr && o_bsy) begin
            o_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xform_buf.sv
// -----------------------------------------------------------------------------
// tb_xform_buf
// Directed bench for xform_buf. One 8-bit/depth-4 instance carries most of the
// scenarios; a 16-bit instance checks that the upper byte passes unchanged.
// -----------------------------------------------------------------------------
module tb_xform_buf;

   logic        i_clk;
   logic        i_rst;
   logic [1:0]  i_mode;
   logic        i_wr;
   logic [7:0]  i_data;
   logic        i_rd;
   logic        o_bsy;
   logic [7:0]  o_data;
   logic        o_rdy;
   logic [2:0]  o_cnt;
   logic        o_ovf;

   logic [1:0]  w_mode;
   logic        w_wr;
   logic [15:0] w_data;
   logic        w_rd;
   logic        w_bsy;
   logic [15:0] w_odata;
   logic        w_rdy;
   logic [2:0]  w_cnt;
   logic        w_ovf;

   int errors;
   int checks;

   xform_buf #(.N(8), .K(2)) u_dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_mode (i_mode),
      .i_wr   (i_wr),
      .i_data (i_data),
      .o_bsy  (o_bsy),
      .i_rd   (i_rd),
      .o_data (o_data),
      .o_rdy  (o_rdy),
      .o_cnt  (o_cnt),
      .o_ovf  (o_ovf)
   );

   xform_buf #(.N(16), .K(2)) u_wide (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_mode (w_mode),
      .i_wr   (w_wr),
      .i_data (w_data),
      .o_bsy  (w_bsy),
      .i_rd   (w_rd),
      .o_data (w_odata),
      .o_rdy  (w_rdy),
      .o_cnt  (w_cnt),
      .o_ovf  (w_ovf)
   );

   // Free-running 10-unit clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_write(input logic [1:0] m, input logic [7:0] d);
      i_mode = m;
      i_data = d;
      i_wr   = 1'b1;
      tick();
      i_wr   = 1'b0;
   endtask

   task automatic do_read();
      i_rd = 1'b1;
      tick();
      i_rd = 1'b0;
   endtask

   // Reset state of every output
   task automatic test_reset();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checks++;
      if (o_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", o_cnt); end
      checks++;
      if ({o_rdy, o_bsy, o_ovf} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got rdy/bsy/ovf=%b expected 000", {o_rdy, o_bsy, o_ovf}); end
      checks++;
      if (o_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", o_data); end
   endtask

   // Swap case: "a","B","1" -> "A","b","1"
   task automatic test_swap_case();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'h41; exp_q[1] = 8'h62; exp_q[2] = 8'h31;
      do_write(2'd1, 8'h61);
      do_write(2'd1, 8'h42);
      do_write(2'd1, 8'h31);
      checks++;
      if (o_cnt !== 3'd3 || o_rdy !== 1'b1) begin errors++; $display("[TB] FAIL swap_fill: got cnt=%0d rdy=%b expected cnt=3 rdy=1", o_cnt, o_rdy); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_data !== exp_q[i]) begin errors++; $display("[TB] FAIL swap_read%0d: got %h expected %h", i, o_data, exp_q[i]); end
         do_read();
      end
      checks++;
      if (o_rdy !== 1'b0 || o_data !== 8'h31) begin errors++; $display("[TB] FAIL swap_empty: got rdy=%b data=%h expected rdy=0 data=31", o_rdy, o_data); end
   endtask

   // Five writes into a depth-4 buffer: last one dropped, overflow sticks
   task automatic test_overflow();
      for (int i = 0; i < 4; i++) do_write(2'd0, 8'h41 + 8'(i));
      checks++;
      if (o_bsy !== 1'b1 || o_cnt !== 3'd4 || o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full: got bsy=%b cnt=%0d ovf=%b expected bsy=1 cnt=4 ovf=0", o_bsy, o_cnt, o_ovf); end
      do_write(2'd0, 8'h45);
      checks++;
      if (o_ovf !== 1'b1 || o_cnt !== 3'd4) begin errors++; $display("[TB] FAIL ovf_set: got ovf=%b cnt=%0d expected ovf=1 cnt=4", o_ovf, o_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (o_data !== 8'h41 + 8'(i)) begin errors++; $display("[TB] FAIL ovf_read%0d: got %h expected %h", i, o_data, 8'h41 + 8'(i)); end
         do_read();
      end
      checks++;
      if (o_rdy !== 1'b0 || o_cnt !== 3'd0 || o_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drained: got rdy=%b cnt=%0d ovf=%b expected rdy=0 cnt=0 ovf=1", o_rdy, o_cnt, o_ovf); end
   endtask

   // Mode changes between writes do not disturb stored entries
   task automatic test_mode_change();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'h51; exp_q[1] = 8'h71; exp_q[2] = 8'h40;
      do_write(2'd2, 8'h71);
      do_write(2'd3, 8'h51);
      do_write(2'd2, 8'h40);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_data !== exp_q[i]) begin errors++; $display("[TB] FAIL mode_read%0d: got %h expected %h", i, o_data, exp_q[i]); end
         do_read();
      end
   endtask

   // Concurrent write and read at occupancy 2; pointers wrap several times
   task automatic test_back_to_back();
      int bad_cnt;
      int bad_data;
      bad_cnt  = 0;
      bad_data = 0;
      do_write(2'd0, 8'h10);
      do_write(2'd0, 8'h11);
      for (int i = 0; i < 10; i++) begin
         i_mode = 2'd0;
         i_data = 8'h12 + 8'(i);
         i_wr   = 1'b1;
         i_rd   = 1'b1;
         checks++;
         if (o_data !== 8'h10 + 8'(i)) begin errors++; bad_data++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, o_data, 8'h10 + 8'(i)); end
         tick();
         checks++;
         if (o_cnt !== 3'd2) begin errors++; bad_cnt++; $display("[TB] FAIL b2b_cnt%0d: got %0d expected 2", i, o_cnt); end
      end
      i_wr = 1'b0;
      i_rd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (o_data !== 8'h1A + 8'(i)) begin errors++; $display("[TB] FAIL b2b_drain%0d: got %h expected %h", i, o_data, 8'h1A + 8'(i)); end
         do_read();
      end
      if (bad_cnt + bad_data != 0) $display("[TB] back_to_back: %0d count and %0d data problems", bad_cnt, bad_data);
   endtask

   // Read+write when empty performs only the write; when full only the read
   task automatic test_full_empty_rw();
      i_mode = 2'd0;
      i_data = 8'h30;
      i_wr   = 1'b1;
      i_rd   = 1'b1;
      tick();
      i_wr   = 1'b0;
      i_rd   = 1'b0;
      checks++;
      if (o_cnt !== 3'd1 || o_data !== 8'h30) begin errors++; $display("[TB] FAIL empty_rw: got cnt=%0d data=%h expected cnt=1 data=30", o_cnt, o_data); end
      for (int i = 1; i < 4; i++) do_write(2'd0, 8'h30 + 8'(i));
      i_data = 8'h34;
      i_wr   = 1'b1;
      i_rd   = 1'b1;
      tick();
      i_wr   = 1'b0;
      i_rd   = 1'b0;
      checks++;
      if (o_cnt !== 3'd3 || o_bsy !== 1'b0 || o_data !== 8'h31) begin errors++; $display("[TB] FAIL full_rw: got cnt=%0d bsy=%b data=%h expected cnt=3 bsy=0 data=31", o_cnt, o_bsy, o_data); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (o_data !== 8'h31 + 8'(i)) begin errors++; $display("[TB] FAIL full_rw_read%0d: got %h expected %h", i, o_data, 8'h31 + 8'(i)); end
         do_read();
      end
      checks++;
      if (o_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_rw_empty: got rdy=%b expected 0", o_rdy); end
   endtask

   // Reset wins over a simultaneous write and clears a full, overflowed buffer
   task automatic test_reset_priority();
      for (int i = 0; i < 5; i++) do_write(2'd0, 8'h50 + 8'(i));
      checks++;
      if (o_bsy !== 1'b1 || o_ovf !== 1'b1) begin errors++; $display("[TB] FAIL rstp_setup: got bsy=%b ovf=%b expected 1 1", o_bsy, o_ovf); end
      i_rst  = 1'b1;
      i_wr   = 1'b1;
      i_data = 8'h77;
      tick();
      i_rst  = 1'b0;
      i_wr   = 1'b0;
      checks++;
      if (o_cnt !== 3'd0 || {o_rdy, o_bsy, o_ovf} !== 3'b000 || o_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rstp_clear: got cnt=%0d rdy/bsy/ovf=%b data=%h expected 0 000 00", o_cnt, {o_rdy, o_bsy, o_ovf}, o_data);
      end
   endtask

   // 16-bit instance: low byte "z" flips to "Z", upper byte untouched
   task automatic test_wide();
      w_mode = 2'd1;
      w_data = 16'hA57A;
      w_wr   = 1'b1;
      tick();
      w_wr   = 1'b0;
      checks++;
      if (w_odata !== 16'hA55A || w_cnt !== 3'd1) begin errors++; $display("[TB] FAIL wide_xform: got data=%h cnt=%0d expected A55A 1", w_odata, w_cnt); end
      w_rd = 1'b1;
      tick();
      w_rd = 1'b0;
      checks++;
      if (w_rdy !== 1'b0 || w_odata !== 16'hA55A) begin errors++; $display("[TB] FAIL wide_read: got rdy=%b data=%h expected 0 A55A", w_rdy, w_odata); end
   endtask

   // Run every scenario in order and print the summary
   initial begin
      errors = 0;
      checks = 0;
      i_rst  = 1'b1;
      i_mode = 2'd0;
      i_wr   = 1'b0;
      i_data = 8'h00;
      i_rd   = 1'b0;
      w_mode = 2'd0;
      w_wr   = 1'b0;
      w_data = 16'h0000;
      w_rd   = 1'b0;
      tick();
      test_reset();
      test_swap_case();
      test_overflow();
      test_mode_change();
      test_back_to_back();
      test_full_empty_rw();
      test_reset_priority();
      test_wide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xform_buf.md
XFORM_BUF -- requirements
Module: xform_buf

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data bus bit width (N >= 8).
REQ-002 The block SHALL have parameter K, default 2, meaning log2 of buffer depth (DEPTH = 2**K entries, K >= 1).
REQ-003 The block SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port i_mode  input  2  transform select, sampled with each accepted write.
REQ-006 The block SHALL have port i_wr  input  1  write request.
REQ-007 The block SHALL have port i_data  input  N  write data.
REQ-008 The block SHALL have port o_bsy  output  1  busy condition (buffer full).
REQ-009 The block SHALL have port i_rd  input  1  read request.
REQ-010 The block SHALL have port o_data  output  N  read data (head entry, registered).
REQ-011 The block SHALL have port o_rdy  output  1  result ready condition (buffer non-empty).
REQ-012 The block SHALL have port o_cnt  output  K+1  current occupancy, 0..DEPTH.
REQ-013 The block SHALL have port o_ovf  output  1  sticky flag, set by any write attempt while busy.

Function
REQ-014 Valid write SHALL be wr = i_wr && !o_bsy; valid read SHALL be rd = i_rd && o_rdy; requests failing these conditions SHALL have no effect on the data path.
REQ-015 Transform on the low 8 bits, chosen by i_mode at the write edge, SHALL be: 0 pass-through; 1 swap case ("A".."Z" and "a".."z" XOR 8'h20); 2 to upper ("a".."z" XOR 8'h20); 3 to lower ("A".."Z" XOR 8'h20).
REQ-016 Characters outside the applicable letter range SHALL pass unchanged; bits N-1:8 SHALL always pass unchanged.
REQ-017 Transformed entries SHALL be stored in strict FIFO order; a mode change SHALL NOT alter entries already stored.
REQ-018 o_rdy SHALL equal (o_cnt != 0), and o_bsy SHALL equal (o_cnt == DEPTH), both registered.
REQ-019 Latency: a write accepted at edge t into an empty buffer SHALL give o_rdy=1 with o_data equal to the transformed value from edge t onward.
REQ-020 o_data SHALL always present the oldest entry while o_rdy=1; after a read at edge t, o_data SHALL show the next entry from edge t, or hold its last value if the buffer becomes empty.
REQ-021 Simultaneous wr and rd with 0 < o_cnt < DEPTH SHALL leave o_cnt unchanged and SHALL both take effect.
REQ-022 When full, i_rd with i_wr SHALL perform only the read (o_bsy blocks the write), and o_bsy SHALL deassert the next cycle.
REQ-023 When empty, i_rd with i_wr SHALL perform only the write, giving o_cnt=1.
REQ-024 Write and read pointers SHALL be K bits and SHALL wrap from DEPTH-1 to 0.
REQ-025 o_ovf SHALL be set at the first edge where i_wr=1 and o_bsy=1, and SHALL stay set until reset.

Reset
REQ-026 While i_rst=1 at a clock edge, o_cnt, both pointers, o_rdy, o_bsy and o_ovf SHALL become 0, and o_data SHALL become 0.
REQ-027 Reset SHALL take priority over simultaneous i_wr/i_rd, and buffered data SHALL be discarded.
REQ-028 Reset during a full or partially full state SHALL yield the empty state at the next cycle.
REQ-029 Storage array contents SHALL NOT require reset.

Verification (N=8, K=2)
REQ-030 The bench SHALL cover: mode=1, write "a","B","1" with no reads -> o_cnt=3, o_rdy=1, o_data="A"; three reads -> "A","b","1", then o_rdy=0 with o_data holding "1".
REQ-031 The bench SHALL cover: 5 consecutive writes of 8'h41..8'h45, mode=0, no reads -> o_bsy=1 after the 4th, o_cnt=4, o_ovf=1 after the 5th, 8'h45 discarded, reads return 8'h41..8'h44.
REQ-032 The bench SHALL cover: mode=2 write "q", mode=3 write "Q", mode=2 write "@" -> reads return "Q","q","@".
REQ-033 The bench SHALL cover: with o_cnt=2, i_wr and i_rd held for 10 cycles with an incrementing data stream -> o_cnt stays 2, output in input order, pointers wrap with no loss.
REQ-034 The bench SHALL cover: full buffer with o_ovf=1, then assert i_rst for one cycle together with i_wr -> next cycle o_cnt=0, o_rdy=0, o_bsy=0, o_ovf=0, o_data=0.
REQ-035 The bench SHALL cover: with N=16, mode=1, write 16'hA5_7A -> read 16'hA5_5A.
